// File: rtl/fifo_read_if.sv
// Consumer-side valid/ready handshake for the async FIFO read controller.
// The master presents words. The slave accepts a word by raising out_ready.
interface fifo_read_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_valid;
  logic                  out_ready;

  modport master (
    output out_data,
    output out_valid,
    input  out_ready
  );

  modport slave (
    input  out_data,
    input  out_valid,
    output out_ready
  );
endinterface

// File: rtl/fifo_read_controller.sv
// Read-domain controller for the async FIFO: write-pointer synchroniser, read pointer
// (binary + registered Gray), memory read address and a single registered output slot.
module fifo_read_controller #(
  parameter  int DATA_WIDTH = 8,
  parameter  int DEPTH      = 8,
  localparam int PTR_WIDTH  = $clog2(DEPTH) + 1,
  localparam int ADDR_WIDTH = $clog2(DATA_WIDTH * (DEPTH - 1))
) (
  input  logic                  read_clk,
  input  logic                  reset,
  input  logic [PTR_WIDTH-1:0]  write_pointer_gray,
  output logic [PTR_WIDTH-1:0]  read_pointer_gray,
  output logic [ADDR_WIDTH-1:0] read_address,
  input  logic [DATA_WIDTH-1:0] read_data,
  fifo_read_if.master           out_bus,
  output logic                  empty,
  output logic [PTR_WIDTH-1:0]  fill_level
);

  logic [PTR_WIDTH-1:0]  wsync1;
  logic [PTR_WIDTH-1:0]  wsync2;
  logic [PTR_WIDTH-1:0]  wbin;
  logic [PTR_WIDTH-1:0]  rptr_bin;
  logic [PTR_WIDTH-1:0]  rptr_gray;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  valid_q;

  logic [PTR_WIDTH-1:0]  rptr_bin_d;
  logic [PTR_WIDTH-1:0]  rptr_gray_d;
  logic [DATA_WIDTH-1:0] data_d;
  logic                  valid_d;

  logic                  mem_empty;
  logic                  load;
  logic                  accept;

  // Each binary bit is the XOR of its Gray bit and every Gray bit above it.
  always_comb begin
    wbin = '0;
    for (int i = 0; i < PTR_WIDTH; i++) begin
      wbin[i] = ^(wsync2 >> i);
    end
  end

  // Status is decoded from registers only, so no input reaches these outputs.
  assign mem_empty  = (rptr_gray == wsync2);
  assign empty      = mem_empty;
  assign fill_level = wbin - rptr_bin;

  // The pointer MSB is only the full/empty lap marker; it never addresses memory.
  assign read_address = ADDR_WIDTH'(rptr_bin[PTR_WIDTH-2:0] * DATA_WIDTH);

  assign read_pointer_gray = rptr_gray;
  assign out_bus.out_data  = data_q;
  assign out_bus.out_valid = valid_q;

  assign accept = valid_q && out_bus.out_ready;
  assign load   = !mem_empty && (!valid_q || out_bus.out_ready);

  // Load takes priority over accept: a simultaneous accept and load replaces the word
  // in the slot and keeps out_valid high, which gives one word per cycle.
  always_comb begin
    // NOTE: every signal gets a hold default before any branch, so no path leaves
    // a value unassigned and no latch is inferred.
    rptr_bin_d  = rptr_bin;
    rptr_gray_d = rptr_gray;
    data_d      = data_q;
    valid_d     = valid_q;
    if (load) begin
      rptr_bin_d  = rptr_bin + PTR_WIDTH'(1);
      rptr_gray_d = rptr_bin_d ^ (rptr_bin_d >> 1);
      data_d      = read_data;
      valid_d     = 1'b1;
    end else if (accept) begin
      valid_d     = 1'b0;
    end
  end

  always_ff @(posedge read_clk) begin
    // NOTE: state is updated with non-blocking assignments so every flop samples
    // the pre-edge values; wsync2 <= wsync1 then forms a true two-stage chain.
    if (!reset) begin
      wsync1    <= '0;
      wsync2    <= '0;
      rptr_bin  <= '0;
      rptr_gray <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
    end else begin
      wsync1    <= write_pointer_gray;
      wsync2    <= wsync1;
      rptr_bin  <= rptr_bin_d;
      rptr_gray <= rptr_gray_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
    end
  end

endmodule

// File: tb/tb_fifo_read_controller.sv
// Scoreboard bench for fifo_read_controller: written words are queued as expected
// consumer data, and a negedge monitor pops and compares each accepted word.
module tb_fifo_read_controller;
  localparam int DW    = 8;
  localparam int DEPTH = 8;
  localparam int PW    = 4;
  localparam int AW    = 6;

  logic          read_clk = 1'b0;
  logic          reset    = 1'b0;
  logic [PW-1:0] write_pointer_gray = '0;
  logic [PW-1:0] read_pointer_gray;
  logic [AW-1:0] read_address;
  logic [DW-1:0] read_data;
  logic          empty;
  logic [PW-1:0] fill_level;

  fifo_read_if #(.DATA_WIDTH(DW)) out_if ();

  fifo_read_controller #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .read_clk           (read_clk),
    .reset              (reset),
    .write_pointer_gray (write_pointer_gray),
    .read_pointer_gray  (read_pointer_gray),
    .read_address       (read_address),
    .read_data          (read_data),
    .out_bus            (out_if),
    .empty              (empty),
    .fill_level         (fill_level)
  );

  always #5 read_clk = ~read_clk;

  // Memory model: combinational read at the word addressed by the bit offset.
  logic [DW-1:0] mem [DEPTH];
  assign read_data = mem[3'(read_address / DW)];

  int            tests = 0;
  int            fails = 0;
  int            wptr  = 0;
  logic [DW-1:0] exp_q [$];

  function automatic logic [PW-1:0] gray(int b);
    logic [PW-1:0] v;
    v = PW'(b);
    return v ^ (v >> 1);
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge read_clk);
    #1;
  endtask

  // Emulates the write side: store the word, advance the pointer by one Gray step.
  task automatic write_word(logic [DW-1:0] v);
    mem[wptr % DEPTH] = v;
    exp_q.push_back(v);
    wptr = (wptr + 1) % (2 * DEPTH);
    write_pointer_gray = gray(wptr);
  endtask

  task automatic do_reset(int n);
    reset = 1'b0;
    wptr = 0;
    write_pointer_gray = '0;
    exp_q.delete();
    repeat (n) tick();
    reset = 1'b1;
  endtask

  // Monitor: a word is accepted at the next edge when valid and ready are both high.
  always @(negedge read_clk) begin
    if (reset && out_if.out_valid && out_if.out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_word", 32'(out_if.out_data), 32'hFFFF_FFFF);
      end else begin
        check("accept_data", 32'(out_if.out_data), 32'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int cycles;
    logic [PW-1:0] prev;

    out_if.out_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) mem[i] = '0;

    // 1. Reset state
    repeat (3) tick();
    check("rst_valid", 32'(out_if.out_valid), 0);
    check("rst_rgray", 32'(read_pointer_gray), 0);
    check("rst_addr",  32'(read_address), 0);
    check("rst_empty", 32'(empty), 1);
    check("rst_fill",  32'(fill_level), 0);
    reset = 1'b1;

    // 2. First word: synchroniser latency, out_valid rises on the 3rd edge
    write_word(8'hA5);
    tick();
    check("lat_e1_valid", 32'(out_if.out_valid), 0);
    tick();
    check("lat_e2_valid", 32'(out_if.out_valid), 0);
    check("lat_e2_fill",  32'(fill_level), 1);
    check("lat_e2_empty", 32'(empty), 0);
    tick();
    check("lat_e3_valid", 32'(out_if.out_valid), 1);
    check("lat_e3_data",  32'(out_if.out_data), 32'hA5);
    check("lat_e3_rgray", 32'(read_pointer_gray), 1);
    check("lat_e3_addr",  32'(read_address), 8);
    check("lat_e3_empty", 32'(empty), 1);

    // 3. Backpressure holds the slot, then back-to-back drain
    write_word(8'h3C);
    tick();
    write_word(8'h5A);
    repeat (3) tick();
    check("bp_valid", 32'(out_if.out_valid), 1);
    check("bp_hold",  32'(out_if.out_data), 32'hA5);
    check("bp_fill",  32'(fill_level), 2);
    check("bp_rgray", 32'(read_pointer_gray), 1);
    out_if.out_ready = 1'b1;
    tick();
    check("drain1_valid", 32'(out_if.out_valid), 1);
    check("drain1_data",  32'(out_if.out_data), 32'h3C);
    check("drain1_rgray", 32'(read_pointer_gray), 32'h3);
    tick();
    check("drain2_data",  32'(out_if.out_data), 32'h5A);
    check("drain2_rgray", 32'(read_pointer_gray), 32'h2);
    check("drain2_fill",  32'(fill_level), 0);
    tick();
    check("drain3_valid", 32'(out_if.out_valid), 0);
    check("drain_queue",  32'(exp_q.size()), 0);

    // 4. Stream 2*DEPTH words: Gray pointer sequence and address wrap
    do_reset(2);
    out_if.out_ready = 1'b1;
    fork
      begin
        for (int i = 0; i < 2 * DEPTH; i++) begin
          write_word(DW'(8'h40 + i));
          tick();
        end
      end
      begin
        k = 1;
        cycles = 0;
        prev = '0;
        while (k <= 2 * DEPTH && cycles < 200) begin
          @(negedge read_clk);
          cycles++;
          if (read_pointer_gray != prev) begin
            check("stream_rgray", 32'(read_pointer_gray), 32'(gray(k)));
            check("stream_addr",  32'(read_address), 32'((k % DEPTH) * DW));
            prev = read_pointer_gray;
            k++;
          end
        end
        if (k <= 2 * DEPTH) check("stream_timeout", 32'(k), 32'(2 * DEPTH + 1));
      end
    join
    repeat (4) tick();
    check("stream_valid_end", 32'(out_if.out_valid), 0);
    check("stream_queue",     32'(exp_q.size()), 0);

    // 5. Full memory: fill_level reaches DEPTH before the first load
    do_reset(2);
    out_if.out_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      mem[i] = DW'(8'h80 + i);
      exp_q.push_back(DW'(8'h80 + i));
    end
    wptr = DEPTH;
    write_pointer_gray = 4'hC;
    tick();
    check("full_e1_fill",  32'(fill_level), 0);
    check("full_e1_empty", 32'(empty), 1);
    tick();
    check("full_e2_fill",  32'(fill_level), 8);
    check("full_e2_empty", 32'(empty), 0);
    check("full_e2_valid", 32'(out_if.out_valid), 0);
    tick();
    check("full_e3_fill",  32'(fill_level), 7);
    check("full_e3_empty", 32'(empty), 0);
    check("full_e3_valid", 32'(out_if.out_valid), 1);
    check("full_e3_data",  32'(out_if.out_data), 32'h80);
    out_if.out_ready = 1'b1;
    repeat (9) tick();
    check("full_drain_valid", 32'(out_if.out_valid), 0);
    check("full_drain_empty", 32'(empty), 1);
    check("full_drain_rgray", 32'(read_pointer_gray), 32'hC);
    check("full_drain_addr",  32'(read_address), 0);
    check("full_queue",       32'(exp_q.size()), 0);

    // 6. Reset mid-operation discards the slot word
    out_if.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      write_word(DW'(8'hC0 + i));
      tick();
    end
    repeat (4) tick();
    check("pre_rst_valid", 32'(out_if.out_valid), 1);
    check("pre_rst_data",  32'(out_if.out_data), 32'hC0);
    check("pre_rst_fill",  32'(fill_level), 3);
    reset = 1'b0;
    wptr = 0;
    write_pointer_gray = '0;
    exp_q.delete();
    tick();
    check("mid_rst_valid", 32'(out_if.out_valid), 0);
    check("mid_rst_rgray", 32'(read_pointer_gray), 0);
    check("mid_rst_fill",  32'(fill_level), 0);
    check("mid_rst_empty", 32'(empty), 1);
    check("mid_rst_addr",  32'(read_address), 0);
    reset = 1'b1;
    repeat (3) tick();
    check("post_rst_valid", 32'(out_if.out_valid), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
